axis_pkt_player: RTL and testbench

- Synthesizable, parametrised AXI-Stream packet player that drives rmt_wrapper-style slave ports with pre-loaded control and data packets.
- Beats are written into an internal beat memory through a simple write port. They are then replayed with:
  - full m_axis_tready backpressure,
  - a programmable inter-packet gap,
  - a programmable loop count.
- Sits in front of the RMT pipeline for on-FPGA bring-up and for reusable simulation stimulus.

---
 rtl/rmt_tb_pkg.sv | 26 ++
 rtl/axis_beat_ram.sv | 25 ++
 rtl/axis_pkt_player.sv | 235 +++++++++++++++++++++++
 tb/tb_axis_pkt_player.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_tb_pkg.sv
// Shared definitions for the AXI-Stream packet player: FSM state encoding,
// the tkeep-width helper and default sizing constants.
package rmt_tb_pkg;

  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned DEF_GAP_W  = 8;
  localparam int unsigned DEF_LOOP_W = 8;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_PLAY  = 2'd1;
  localparam logic [1:0] ENC_GAP   = 2'd2;
  localparam logic [1:0] ENC_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_PLAY  = ENC_PLAY,
    ST_GAP   = ENC_GAP,
    ST_FLUSH = ENC_FLUSH
  } player_state_e;

  // One tkeep bit per tdata byte.
  function automatic int unsigned keep_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axis_beat_ram.sv
// Beat memory for the packet player: DEPTH entries of packed
// {tdata, tkeep, tuser, tlast}. Synchronous write, asynchronous read, no reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data_c (combinational).
module axis_beat_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_player.sv
// AXI-Stream packet player: replays beats pre-loaded into a beat memory with
// full tready backpressure, a programmable gap after each tlast beat and a
// programmable pass count (0 = loop until stop).
// Ports: clk, aresetn (async, active-low); wr_* beat memory write port;
// start/stop/num_beats/gap_cycles/loop_cnt playback control; busy/done status;
// m_axis_* registered AXI-Stream master.
// Optional: define AXIS_PKT_PLAYER_STATS_EN to add pkt_count/beat_count outputs.
module axis_pkt_player
  import rmt_tb_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned DEPTH                = DEF_DEPTH,
  parameter int unsigned ADDR_W               = $clog2(DEPTH),
  parameter int unsigned GAP_W                = DEF_GAP_W,
  parameter int unsigned LOOP_W               = DEF_LOOP_W,
  localparam int unsigned KEEP_W              = keep_width(C_M_AXIS_DATA_WIDTH)
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]  wr_data,
  input  logic [KEEP_W-1:0]               wr_keep,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0] wr_user,
  input  logic                            wr_last,
  input  logic                            start,
  input  logic                            stop,
  input  logic [ADDR_W:0]                 num_beats,
  input  logic [GAP_W-1:0]                gap_cycles,
  input  logic [LOOP_W-1:0]               loop_cnt,
  output logic                            busy,
  output logic                            done,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_W-1:0]               m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
`ifdef AXIS_PKT_PLAYER_STATS_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     beat_count
`endif
);

  localparam int unsigned BEAT_W = C_M_AXIS_DATA_WIDTH + KEEP_W + C_M_AXIS_TUSER_WIDTH + 1;

  player_state_e     state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;     // next address to load into the output register
  logic [ADDR_W:0]   nbeats_q, nbeats_d;
  logic [GAP_W-1:0]  gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [LOOP_W-1:0] loops_q, loops_d;       // passes still to play (unused when infinite)
  logic              infinite_q, infinite_d;
  logic              stop_q, stop_d;
  logic              wrap_q, wrap_d;         // beat in output register is the last of its pass
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tvalid_q, tvalid_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] ram_rdata_c;
  logic [ADDR_W-1:0] last_idx;
  logic              accept;
  logic              load;
  logic              final_pass;

  axis_beat_ram #(
    .WIDTH  (BEAT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   ({wr_data, wr_keep, wr_user, wr_last}),
    .rd_addr   (rd_ptr_q),
    .rd_data_c (ram_rdata_c)
  );

  assign accept = tvalid_q & m_axis_tready;

  // Next-state, counters and output-register load decision.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    nbeats_d   = nbeats_q;
    gap_cfg_d  = gap_cfg_q;
    gap_cnt_d  = gap_cnt_q;
    loops_d    = loops_q;
    infinite_d = infinite_q;
    stop_d     = stop_q;
    wrap_d     = wrap_q;
    done_d     = 1'b0;
    tvalid_d   = tvalid_q;
    beat_d     = beat_q;
    load       = 1'b0;
    final_pass = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          if (num_beats == '0) begin
            done_d = 1'b1;
          end else begin
            nbeats_d   = num_beats;
            gap_cfg_d  = gap_cycles;
            loops_d    = loop_cnt;
            infinite_d = (loop_cnt == '0);
            rd_ptr_d   = '0;
            load       = 1'b1;
            state_d    = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        stop_d = stop_q | stop;
        if (accept) begin
          final_pass = wrap_q & ~infinite_q & (loops_q == LOOP_W'(1));
          if (wrap_q && !infinite_q) loops_d = loops_q - LOOP_W'(1);
          // Stop only takes effect on a tlast beat so a packet is never cut short.
          if (final_pass || (beat_q[0] && (stop_q || stop))) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_FLUSH;
          end else if (beat_q[0] && (gap_cfg_q != '0)) begin
            tvalid_d  = 1'b0;
            gap_cnt_d = gap_cfg_q;
            state_d   = ST_GAP;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        stop_d = stop_q | stop;
        if (gap_cnt_q == GAP_W'(1)) begin
          load    = 1'b1;
          state_d = ST_PLAY;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_FLUSH: begin
        tvalid_d = 1'b0;
        stop_d   = 1'b0;
        rd_ptr_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Uses the freshly latched beat count so the start cycle loads correctly.
    last_idx = ADDR_W'(nbeats_d - (ADDR_W+1)'(1));
    if (load) begin
      tvalid_d = 1'b1;
      beat_d   = ram_rdata_c;
      wrap_d   = (rd_ptr_q == last_idx);
      rd_ptr_d = wrap_d ? '0 : rd_ptr_q + ADDR_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      nbeats_q   <= '0;
      gap_cfg_q  <= '0;
      gap_cnt_q  <= '0;
      loops_q    <= '0;
      infinite_q <= 1'b0;
      stop_q     <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tvalid_q   <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      nbeats_q   <= nbeats_d;
      gap_cfg_q  <= gap_cfg_d;
      gap_cnt_q  <= gap_cnt_d;
      loops_q    <= loops_d;
      infinite_q <= infinite_d;
      stop_q     <= stop_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tvalid_q   <= tvalid_d;
      beat_q     <= beat_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = beat_q;

`ifdef AXIS_PKT_PLAYER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  // Saturating accepted-beat / accepted-tlast counters, cleared by a start in IDLE.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      pkt_cnt_d  = '0;
      beat_cnt_d = '0;
    end else if (accept) begin
      if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 32'd1;
      if (beat_q[0] && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_player.sv
// Testbench for axis_pkt_player: randomized beat contents and backpressure,
// checked against a pass/packet-level model of the replay sequence and timing.
module tb_axis_pkt_player;

  localparam int unsigned DW    = 32;
  localparam int unsigned UW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned BW    = DW + KW + UW + 1;

  logic          clk;
  logic          aresetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [KW-1:0] wr_keep;
  logic [UW-1:0] wr_user;
  logic          wr_last;
  logic          start;
  logic          stop;
  logic [AW:0]   num_beats;
  logic [7:0]    gap_cycles;
  logic [7:0]    loop_cnt;
  logic          busy;
  logic          done;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;

  axis_pkt_player #(
    .C_M_AXIS_DATA_WIDTH  (DW),
    .C_M_AXIS_TUSER_WIDTH (UW),
    .DEPTH                (DEPTH),
    .ADDR_W               (AW),
    .GAP_W                (8),
    .LOOP_W               (8)
  ) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_keep       (wr_keep),
    .wr_user       (wr_user),
    .wr_last       (wr_last),
    .start         (start),
    .stop          (stop),
    .num_beats     (num_beats),
    .gap_cycles    (gap_cycles),
    .loop_cnt      (loop_cnt),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench copy of everything written into the beat memory; bit 0 is tlast.
  logic [BW-1:0] mem_m [DEPTH];
  int exp_a[$];

  typedef struct {
    logic [BW-1:0] beat;
    int            cyc;
  } acc_t;
  acc_t acc_q[$];

  int            ncyc = 0;
  int            start_cyc = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            stall_viol = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  logic [BW-1:0] out_beat;

  assign out_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};

  // Negedge monitor: records accepted beats, done pulses and stalls that moved.
  always @(negedge clk) begin
    ncyc++;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (start) start_cyc = ncyc;
      if (done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      if (prev_stall && (!m_axis_tvalid || out_beat !== prev_beat)) stall_viol++;
      if (m_axis_tvalid && m_axis_tready) acc_q.push_back('{beat: out_beat, cyc: ncyc});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = out_beat;
    end
  end

  function automatic logic [BW-1:0] rand_beat(input logic last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    d = DW'($urandom);
    k = KW'($urandom);
    u = UW'($urandom);
    return {d, k, u, last};
  endfunction

  task automatic write_beat(input int a, input logic [BW-1:0] b);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    {wr_data, wr_keep, wr_user, wr_last} = b;
    mem_m[a] = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Two packets in addresses 0-2 (tlast on 1 and 2), random filler elsewhere.
  task automatic load_plan();
    write_beat(0, rand_beat(1'b0));
    write_beat(1, rand_beat(1'b1));
    write_beat(2, rand_beat(1'b1));
    for (int a = 3; a < DEPTH; a++) write_beat(a, rand_beat(1'($urandom)));
  endtask

  // Expected address order: whole passes, cut at the first tlast beat at or
  // after the beat during which stop was raised.
  function automatic void build_exp(input int nb, input int loops, input int stop_after);
    exp_a.delete();
    for (int p = 0; (loops == 0 || p < loops) && exp_a.size() < 200; p++) begin
      for (int i = 0; i < nb; i++) begin
        exp_a.push_back(i);
        if (stop_after >= 0 && exp_a.size() > stop_after && mem_m[i][0]) return;
      end
    end
  endfunction

  // mode 0: tready=1; mode 1: random tready; mode 2: tready 1,0,0,1 from the start cycle.
  task automatic play(input string name, input int nb, input int gap, input int loops,
                      input int mode, input int stop_after);
    bit seen;
    bit stop_sent;
    int k;
    int ec;
    acc_q.delete();
    done_cnt   = 0;
    stall_viol = 0;
    @(posedge clk); #1;
    num_beats     = (AW+1)'(nb);
    gap_cycles    = 8'(gap);
    loop_cnt      = 8'(loops);
    start         = 1'b1;
    m_axis_tready = (mode == 1) ? 1'($urandom) : 1'b1;
    seen = 0;
    stop_sent = 0;
    k = 1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      if (mode == 1) m_axis_tready = 1'($urandom);
      else if (mode == 2) m_axis_tready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      k++;
      if (stop_after >= 0 && !stop_sent && acc_q.size() == stop_after) begin
        stop = 1'b1;
        stop_sent = 1;
      end
      if (done_cnt > 0) seen = 1;
    end
    m_axis_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done pulse, beats seen %0d", name, acc_q.size());
    end
    build_exp(nb, loops, stop_after);
    checks++;
    if (acc_q.size() !== exp_a.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d expected %0d", name, acc_q.size(), exp_a.size());
    end else begin
      ec = start_cyc + ((mode == 2) ? 3 : 1);
      for (int j = 0; j < exp_a.size(); j++) begin
        if (j > 0) ec = ec + 1 + ((gap > 0 && mem_m[exp_a[j-1]][0]) ? gap : 0);
        checks++;
        if (acc_q[j].beat !== mem_m[exp_a[j]]) begin
          errors++;
          $display("FAIL %s beat[%0d]: got %h expected %h (addr %0d)", name, j,
                   acc_q[j].beat, mem_m[exp_a[j]], exp_a[j]);
        end
        if (mode != 1) begin
          checks++;
          if (acc_q[j].cyc !== ec) begin
            errors++;
            $display("FAIL %s accept_cycle[%0d]: got %0d expected %0d", name, j,
                     acc_q[j].cyc - start_cyc, ec - start_cyc);
          end
        end
      end
      if (acc_q.size() > 0) begin
        checks++;
        if (done_cyc !== acc_q[acc_q.size()-1].cyc + 1) begin
          errors++;
          $display("FAIL %s done_timing: got %0d expected %0d", name, done_cyc,
                   acc_q[acc_q.size()-1].cyc + 1);
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++;
      $display("FAIL %s stall_stability: got %0d changes expected 0", name, stall_viol);
    end
    checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b tvalid=%b expected 0 0", name, busy, m_axis_tvalid);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got tvalid=%b busy=%b done=%b expected 0 0 0",
               m_axis_tvalid, busy, done);
    end
    checks++;
    if (out_beat !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", out_beat);
    end
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_single_pass();
    play("single_pass", 3, 0, 1, 0, -1);
  endtask

  task automatic test_gap();
    play("gap20", 3, 20, 1, 0, -1);
  endtask

  task automatic test_backpressure();
    play("backpressure", 3, 0, 1, 2, -1);
  endtask

  task automatic test_loop();
    play("loop3", 3, 0, 3, 0, -1);
  endtask

  task automatic test_stop();
    play("stop_infinite", 3, 0, 0, 0, 3);
  endtask

  task automatic test_zero_beats();
    acc_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    num_beats = '0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 1 || done_cyc !== start_cyc + 1) begin
      errors++;
      $display("FAIL zero_beats_done: got %0d pulses at +%0d expected 1 at +1",
               done_cnt, done_cyc - start_cyc);
    end
    checks++;
    if (acc_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_beats_idle: got %0d beats busy=%b expected 0 beats busy=0",
               acc_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid_beat();
    m_axis_tready = 1'b0;
    @(posedge clk); #1;
    num_beats  = 5'd3;
    gap_cycles = 8'd0;
    loop_cnt   = 8'd1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || out_beat !== mem_m[0]) begin
      errors++;
      $display("FAIL reset_mid_pre: got tvalid=%b beat=%h expected 1 %h",
               m_axis_tvalid, out_beat, mem_m[0]);
    end
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: got tvalid=%b busy=%b expected 0 0", m_axis_tvalid, busy);
    end
    @(posedge clk); #1;
    aresetn = 1'b1;
    m_axis_tready = 1'b1;
    play("replay_after_reset", 3, 0, 1, 0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < DEPTH; a++) write_beat(a, rand_beat(1'($urandom)));
      play($sformatf("random%0d", it), $urandom_range(1, DEPTH), $urandom_range(0, 3),
           $urandom_range(1, 3), 1, -1);
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_keep       = '0;
    wr_user       = '0;
    wr_last       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    num_beats     = '0;
    gap_cycles    = '0;
    loop_cnt      = '0;
    m_axis_tready = 1'b1;

    test_reset();
    load_plan();
    test_single_pass();
    test_gap();
    test_backpressure();
    test_loop();
    test_stop();
    test_zero_beats();
    test_reset_mid_beat();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
